// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD power sequencer: state encodings and default
// panel timing constants, also used by the top level and lvds serializer setup.
package lcd_pkg;

   localparam int LCD_STATE_W = 3;

   typedef enum logic [LCD_STATE_W-1:0] {
      ST_OFF       = 3'd0,
      ST_VDD_UP    = 3'd1,
      ST_LVDS_UP   = 3'd2,
      ST_ON        = 3'd3,
      ST_BL_DOWN   = 3'd4,
      ST_LVDS_DOWN = 3'd5,
      ST_OFF_HOLD  = 3'd6
   } lcd_state_e;

   // Panel datasheet delays in system clock cycles.
   localparam int LCD_T_VDD_LVDS_DEF = 1_000_000;
   localparam int LCD_T_LVDS_BL_DEF  = 20_000_000;
   localparam int LCD_T_BL_LVDS_DEF  = 20_000_000;
   localparam int LCD_T_LVDS_VDD_DEF = 1_000_000;
   localparam int LCD_T_OFF_MIN_DEF  = 50_000_000;
   localparam int LCD_TW_DEF         = 26;
   localparam int LCD_PWM_DIV_DEF    = 256;

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: prescaled 8-bit free-running counter with a duty latch that
// only reloads on the 255->0 wrap, so duty changes never split a period.
module lcd_bl_pwm #(
   parameter int PWM_DIV = 256
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_duty,
   output logic       o_pwm
);

   localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    duty_q, duty_d;
   logic          tick;

   always_comb begin
      tick    = (presc_q == PW'(PWM_DIV - 1));
      presc_d = tick ? '0 : presc_q + PW'(1);
      cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
      duty_d  = (tick && (cnt_q == 8'hFF)) ? i_duty : duty_q;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         presc_q <= '0;
         cnt_q   <= '0;
         duty_q  <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
      end
   end

   assign o_pwm = (cnt_q < duty_q);

endmodule

// File: rtl/lcd_power_seq.sv
// LVDS panel power sequencer: VDD -> LVDS -> backlight up, reverse on the way
// down, fault forces OFF_HOLD. Macro LCD_POWER_SEQ_BL_PWM_EN adds backlight PWM.
module lcd_power_seq
   import lcd_pkg::*;
#(
   parameter int T_VDD_LVDS = LCD_T_VDD_LVDS_DEF,
   parameter int T_LVDS_BL  = LCD_T_LVDS_BL_DEF,
   parameter int T_BL_LVDS  = LCD_T_BL_LVDS_DEF,
   parameter int T_LVDS_VDD = LCD_T_LVDS_VDD_DEF,
   parameter int T_OFF_MIN  = LCD_T_OFF_MIN_DEF,
   parameter int TW         = LCD_TW_DEF,
   parameter int PWM_DIV    = LCD_PWM_DIV_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_enable,
   input  logic                   i_frame_start,
   input  logic                   i_fault,
`ifdef LCD_POWER_SEQ_BL_PWM_EN
   input  logic [7:0]             i_bl_duty,
`endif
   output logic                   o_vdd_en,
   output logic                   o_lvds_en,
   output logic                   o_bl_en,
   output logic                   o_ready,
   output logic [LCD_STATE_W-1:0] o_state
);

   lcd_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          expired;
   logic          vdd_q, lvds_q, on_q;

   // Fault wins over everything; enable drops only abort the rising phases.
   always_comb begin
      expired = (timer_q == '0);
      state_d = state_q;
      if (i_fault && (state_q != ST_OFF) && (state_q != ST_OFF_HOLD)) begin
         state_d = ST_OFF_HOLD;
      end else begin
         case (state_q)
            ST_OFF:       if (i_enable && !i_fault) state_d = ST_VDD_UP;
            ST_VDD_UP:    if (!i_enable) state_d = ST_OFF_HOLD;
                          else if (expired) state_d = ST_LVDS_UP;
            ST_LVDS_UP:   if (!i_enable) state_d = ST_LVDS_DOWN;
                          else if (expired && i_frame_start) state_d = ST_ON;
            ST_ON:        if (!i_enable) state_d = ST_BL_DOWN;
            ST_BL_DOWN:   if (expired) state_d = ST_LVDS_DOWN;
            ST_LVDS_DOWN: if (expired) state_d = ST_OFF_HOLD;
            ST_OFF_HOLD:  if (expired) state_d = ST_OFF;
            default:      state_d = ST_OFF_HOLD;
         endcase
      end
   end

   // Reload on any state change (including escape from the unused encoding).
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         case (state_d)
            ST_VDD_UP:    timer_d = TW'(T_VDD_LVDS - 1);
            ST_LVDS_UP:   timer_d = TW'(T_LVDS_BL - 1);
            ST_BL_DOWN:   timer_d = TW'(T_BL_LVDS - 1);
            ST_LVDS_DOWN: timer_d = TW'(T_LVDS_VDD - 1);
            ST_OFF_HOLD:  timer_d = TW'(T_OFF_MIN - 1);
            default:      timer_d = '0;
         endcase
      end else if (!expired) begin
         timer_d = timer_q - TW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_OFF;
         timer_q <= '0;
         vdd_q   <= 1'b0;
         lvds_q  <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         vdd_q   <= (state_d == ST_VDD_UP) || (state_d == ST_LVDS_UP) ||
                    (state_d == ST_ON) || (state_d == ST_BL_DOWN) ||
                    (state_d == ST_LVDS_DOWN);
         lvds_q  <= (state_d == ST_LVDS_UP) || (state_d == ST_ON) ||
                    (state_d == ST_BL_DOWN);
         on_q    <= (state_d == ST_ON);
      end
   end

`ifdef LCD_POWER_SEQ_BL_PWM_EN
   logic pwm_on;

   lcd_bl_pwm #(
      .PWM_DIV (PWM_DIV)
   ) u_bl_pwm (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_duty  (i_bl_duty),
      .o_pwm   (pwm_on)
   );

   assign o_bl_en = on_q && pwm_on;
`else
   assign o_bl_en = on_q;
`endif

   assign o_vdd_en  = vdd_q;
   assign o_lvds_en = lvds_q;
   assign o_ready   = on_q;
   assign o_state   = state_q;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Randomized bench for lcd_power_seq against a phase/age reference model,
// plus directed power-up/power-down timestamps and a mid-sequence async reset.
module tb_lcd_power_seq;

   localparam int TVL  = 4;
   localparam int TLB  = 6;
   localparam int TBL  = 5;
   localparam int TLV  = 3;
   localparam int TOFF = 8;
   localparam int NCYC = 4000;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       frameStart;
   logic       fault;
   logic [7:0] blDuty;
   logic       vddEn, lvdsEn, blEn, ready;
   logic [2:0] state;

   int vectorCount = 0;
   int missCount   = 0;

   // Reference model: phase number and cycles spent in it (1 on entry).
   int phase  = 0;
   int age    = 0;
   int pwmCnt = 0;
   int dutyM  = 0;

   always #5 clock = ~clock;

   lcd_power_seq #(
      .T_VDD_LVDS (TVL),
      .T_LVDS_BL  (TLB),
      .T_BL_LVDS  (TBL),
      .T_LVDS_VDD (TLV),
      .T_OFF_MIN  (TOFF),
      .TW         (8),
      .PWM_DIV    (1)
   ) dut (
      .i_clk         (clock),
      .i_reset       (reset),
      .i_enable      (enable),
      .i_frame_start (frameStart),
      .i_fault       (fault),
`ifdef LCD_POWER_SEQ_BL_PWM_EN
      .i_bl_duty     (blDuty),
`endif
      .o_vdd_en      (vddEn),
      .o_lvds_en     (lvdsEn),
      .o_bl_en       (blEn),
      .o_ready       (ready),
      .o_state       (state)
   );

   task automatic checkOutput(input string tag, input int obs, input int exp);
      vectorCount++;
      if (obs != exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int phaseLen(input int ph);
      case (ph)
         1:       return TVL;
         2:       return TLB;
         4:       return TBL;
         5:       return TLV;
         6:       return TOFF;
         default: return 0;
      endcase
   endfunction

   task automatic modelStep(input bit en, input bit fs, input bit flt, input int duty);
      int nxt;
      bit done;
      nxt  = phase;
      done = (age >= phaseLen(phase));
      if (flt && phase != 0 && phase != 6) nxt = 6;
      else begin
         case (phase)
            0: if (en && !flt) nxt = 1;
            1: nxt = !en ? 6 : (done ? 2 : 1);
            2: nxt = !en ? 5 : ((done && fs) ? 3 : 2);
            3: if (!en) nxt = 4;
            4: if (done) nxt = 5;
            5: if (done) nxt = 6;
            6: if (done) nxt = 0;
            default: nxt = 6;
         endcase
      end
      age   = (nxt != phase) ? 1 : age + 1;
      phase = nxt;
      if (pwmCnt == 255) begin
         pwmCnt = 0;
         dutyM  = duty;
      end else begin
         pwmCnt++;
      end
   endtask

   task automatic checkModel();
      int expBl;
`ifdef LCD_POWER_SEQ_BL_PWM_EN
      expBl = (phase == 3 && pwmCnt < dutyM) ? 1 : 0;
`else
      expBl = (phase == 3) ? 1 : 0;
`endif
      checkOutput("state", int'(state), phase);
      checkOutput("vdd_en", int'(vddEn), (phase >= 1 && phase <= 5) ? 1 : 0);
      checkOutput("lvds_en", int'(lvdsEn), (phase >= 2 && phase <= 4) ? 1 : 0);
      checkOutput("bl_en", int'(blEn), expBl);
      checkOutput("ready", int'(ready), (phase == 3) ? 1 : 0);
   endtask

   task automatic applyStimulus(input int c);
      if (c < 40) begin
         enable     = 1'b1;
         frameStart = (c == 20);
         fault      = 1'b0;
         blDuty     = 8'd64;
      end else if (c < 60) begin
         enable     = 1'b0;
         frameStart = (c == 45);
         fault      = 1'b0;
      end else begin
         if ($urandom_range(0, 59) == 0) enable = ~enable;
         frameStart = ($urandom_range(0, 4) == 0);
         fault      = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 299) == 0) begin
            case ($urandom_range(0, 4))
               0:       blDuty = 8'd0;
               1:       blDuty = 8'd64;
               2:       blDuty = 8'd128;
               3:       blDuty = 8'd255;
               default: blDuty = 8'($urandom_range(0, 255));
            endcase
         end
      end
   endtask

   initial begin
      int vddOn, lvdsOn, blOn, blOff, lvdsOff, vddOff, offAgain;
      bit resetDone;
      vddOn = -1; lvdsOn = -1; blOn = -1;
      blOff = -1; lvdsOff = -1; vddOff = -1; offAgain = -1;
      resetDone  = 1'b0;
      reset      = 1'b1;
      enable     = 1'b0;
      frameStart = 1'b0;
      fault      = 1'b0;
      blDuty     = 8'd0;

      #3;
      checkModel();
      @(negedge clock);
      reset = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
         applyStimulus(c);
         @(posedge clock);
         modelStep(enable, frameStart, fault, int'(blDuty));
         @(negedge clock);
         checkModel();

         if (c < 40) begin
            if (vddEn && vddOn < 0)   vddOn  = c + 1;
            if (lvdsEn && lvdsOn < 0) lvdsOn = c + 1;
            if (blEn && blOn < 0)     blOn   = c + 1;
         end else if (c < 60) begin
            if (!blEn && blOff < 0)         blOff    = c + 1;
            if (!lvdsEn && lvdsOff < 0)     lvdsOff  = c + 1;
            if (!vddEn && vddOff < 0)       vddOff   = c + 1;
            if (state == 3'd0 && offAgain < 0) offAgain = c + 1;
         end
         if (c == 59) begin
            checkOutput("t_vdd_on", vddOn, 1);
            checkOutput("t_lvds_on", lvdsOn, 5);
`ifndef LCD_POWER_SEQ_BL_PWM_EN
            checkOutput("t_bl_on", blOn, 21);
`endif
            checkOutput("t_bl_off", blOff, 41);
            checkOutput("t_lvds_off", lvdsOff, 46);
            checkOutput("t_vdd_off", vddOff, 49);
            checkOutput("t_off_again", offAgain, 57);
         end

         // Async reset landing between edges while LVDS is coming up.
         if (!resetDone && c > 200 && phase == 2) begin
            resetDone = 1'b1;
            #2;
            reset = 1'b1;
            #1;
            checkOutput("rst_vdd", int'(vddEn), 0);
            checkOutput("rst_lvds", int'(lvdsEn), 0);
            checkOutput("rst_state", int'(state), 0);
            @(negedge clock);
            reset  = 1'b0;
            phase  = 0;
            age    = 0;
            pwmCnt = 0;
            dutyM  = 0;
         end
      end

      checkOutput("reset_hit", int'(resetDone), 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
